// File: rtl/aes_inv_sched_pkg.sv
// Shared types and constants for the aes_inv_sched job scheduler.
package aes_inv_sched_pkg;
    localparam int AES_BLK_W = 128;
    localparam int REQ_ID_W  = 2;

    typedef enum logic [2:0] {IDLE, KEXP, LOAD, RUN, RESP} sched_state_t;

    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] text;
        logic [REQ_ID_W-1:0]  id;
    } job_t;
endpackage

// File: rtl/aes_inv_sched_if.sv
// Requester, response and core-side signal bundle for aes_inv_sched.
interface aes_inv_sched_if #(parameter int N_REQ = 2);
    import aes_inv_sched_pkg::*;

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][AES_BLK_W-1:0] req_key;
    logic [N_REQ-1:0][AES_BLK_W-1:0] req_text;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [REQ_ID_W-1:0]             rsp_id;
    logic [AES_BLK_W-1:0]            rsp_text;
    logic                            core_kld;
    logic                            core_ld;
    logic [AES_BLK_W-1:0]            core_key;
    logic [AES_BLK_W-1:0]            core_text_in;
    logic                            core_done;
    logic [AES_BLK_W-1:0]            core_text_out;

    // slave: the scheduler; master: requesters, consumer and core around it
    modport slave (
        input  req_valid, req_key, req_text, rsp_ready, core_done, core_text_out,
        output req_ready, rsp_valid, rsp_id, rsp_text, core_kld, core_ld, core_key, core_text_in
    );
    modport master (
        output req_valid, req_key, req_text, rsp_ready, core_done, core_text_out,
        input  req_ready, rsp_valid, rsp_id, rsp_text, core_kld, core_ld, core_key, core_text_in
    );
endinterface

// File: rtl/aes_inv_sched_arb.sv
// Combinational round-robin picker: first request at or after rr_ptr, wrapping.
module aes_rr_arb
    import aes_inv_sched_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [REQ_ID_W-1:0] rr_ptr,
    output logic [N_REQ-1:0]    gnt,
    output logic [REQ_ID_W-1:0] gnt_id
);
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(rr_ptr) + k) % N_REQ)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    gnt_id = REQ_ID_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/aes_inv_sched.sv
// Round-robin scheduler sharing one aes_inv_cipher core between N_REQ requesters.
// Optional key cache (skip key expansion on repeated key): AES_INV_SCHED_KEYCACHE_EN.
module aes_inv_sched
    import aes_inv_sched_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int KEY_WAIT = 13
) (
    input  logic           clk,
    input  logic           rst,
    aes_inv_sched_if.slave bus
);
    localparam int                  WCNT_W    = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;
    localparam logic [WCNT_W-1:0]   WCNT_LAST = WCNT_W'(KEY_WAIT - 1);
    localparam logic [REQ_ID_W-1:0] ID_LAST   = REQ_ID_W'(N_REQ - 1);

    sched_state_t         state;
    job_t                 job_r;
    logic [REQ_ID_W-1:0]  rr_ptr;
    logic [REQ_ID_W-1:0]  gnt_id;
    logic [N_REQ-1:0]     gnt;
    logic [WCNT_W-1:0]    wcnt;
    logic                 kld_r, ld_r, rsp_valid_r;
    logic [REQ_ID_W-1:0]  rsp_id_r;
    logic [AES_BLK_W-1:0] rsp_text_r;
    logic [AES_BLK_W-1:0] sel_key, sel_text;
    logic                 hit;

    aes_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // one-hot select of the granted requester's payload
    always_comb begin
        sel_key  = '0;
        sel_text = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_key  = bus.req_key[i];
                sel_text = bus.req_text[i];
            end
        end
    end

`ifdef AES_INV_SCHED_KEYCACHE_EN
    logic                 kvalid;
    logic [AES_BLK_W-1:0] kcache;

    assign hit = kvalid && (sel_key == kcache);

    // the core holds the key only once a full expansion window has elapsed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kvalid <= 1'b0;
            kcache <= '0;
        end else if (state == KEXP && wcnt == WCNT_LAST) begin
            kvalid <= 1'b1;
            kcache <= job_r.key;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            job_r       <= '0;
            rr_ptr      <= '0;
            wcnt        <= '0;
            kld_r       <= 1'b0;
            ld_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_text_r  <= '0;
        end else begin
            kld_r <= 1'b0;
            ld_r  <= 1'b0;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    job_r.key  <= sel_key;
                    job_r.text <= sel_text;
                    job_r.id   <= gnt_id;
                    wcnt       <= '0;
                    if (hit) begin
                        ld_r  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        kld_r <= 1'b1;
                        state <= KEXP;
                    end
                end
                KEXP: if (wcnt == WCNT_LAST) begin
                    ld_r  <= 1'b1;
                    state <= LOAD;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                LOAD: state <= RUN;
                RUN: if (bus.core_done) begin
                    rsp_text_r  <= bus.core_text_out;
                    rsp_id_r    <= job_r.id;
                    rsp_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_r <= 1'b0;
                    rr_ptr      <= (job_r.id == ID_LAST) ? '0 : job_r.id + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // accept pulse lands in the grant cycle so the payload is latched on the same edge
    assign bus.req_ready    = (state == IDLE) ? gnt : '0;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_id       = rsp_id_r;
    assign bus.rsp_text     = rsp_text_r;
    assign bus.core_kld     = kld_r;
    assign bus.core_ld      = ld_r;
    assign bus.core_key     = job_r.key;
    assign bus.core_text_in = job_r.text;
endmodule

// File: tb/tb_aes_inv_sched.sv
// Self-checking bench for aes_inv_sched with a behavioural stand-in for the core.
module tb_aes_inv_sched;
    localparam int N  = 4;
    localparam int KW = 13;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        int           id;
        logic [127:0] txt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    aes_inv_sched_if #(.N_REQ(N)) bus();
    aes_inv_sched #(.N_REQ(N), .KEY_WAIT(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // core stand-in: known FIPS-197 vector, otherwise a keyed scramble
    function automatic logic [127:0] dec(input logic [127:0] k, input logic [127:0] t);
        if (k == K0 && t == C0) return P0;
        return t ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    logic [127:0] m_key, m_text, m_out;
    logic [2:0]   m_cnt;
    logic         m_busy, m_done, spur;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_key <= '0; m_text <= '0; m_out <= '0; m_cnt <= '0; m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (bus.core_kld) m_key <= bus.core_key;
            if (bus.core_ld) begin
                m_text <= bus.core_text_in; m_cnt <= 3'd3; m_busy <= 1'b1;
            end else if (m_busy) begin
                if (m_cnt == 3'd0) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_out <= dec(m_key, m_text);
                end else m_cnt <= m_cnt - 3'd1;
            end
        end
    end
    assign bus.core_done     = m_done | spur;
    assign bus.core_text_out = m_out;

    // monitor: event counters, timestamps, grant order, observed responses
    int   kld_n = 0, ld_n = 0, both_n = 0;
    int   kld_cyc = 0, ld_cyc = 0, gnt_cyc = 0, done_cyc = 0, rise_cyc = 0;
    logic prev_rv = 1'b0;
    int   gnt_q[$];
    int   obs_id[$];
    logic [127:0] obs_txt[$];
    exp_t exp_q[$];

    always @(negedge clk) begin
        prev_rv <= bus.rsp_valid;
        if (rst) begin
            if (bus.core_kld) begin kld_n <= kld_n + 1; kld_cyc <= cyc; end
            if (bus.core_ld) begin ld_n <= ld_n + 1; ld_cyc <= cyc; end
            if (bus.core_kld && bus.core_ld) both_n <= both_n + 1;
            if (bus.core_done) done_cyc <= cyc;
            if (bus.rsp_valid && !prev_rv) rise_cyc <= cyc;
            for (int i = 0; i < N; i++)
                if (bus.req_ready[i]) begin gnt_q.push_back(i); gnt_cyc <= cyc; end
            if (bus.rsp_valid && bus.rsp_ready) begin
                obs_id.push_back(int'(bus.rsp_id));
                obs_txt.push_back(bus.rsp_text);
            end
        end
    end

    // raise a request, wait for its accept pulse, record expectation, withdraw
    task automatic req_job(input int id, input logic [127:0] k, input logic [127:0] t);
        int   n;
        exp_t e;
        bus.req_key[id]   = k;
        bus.req_text[id]  = t;
        bus.req_valid[id] = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.req_ready[id] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (bus.req_ready[id] !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL grant_timeout requester=%0d got=no grant exp=grant", id);
        end else begin
            e.id = id; e.txt = dec(k, t);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_id.size() < n && t < 1000) begin @(negedge clk); t++; end
        if (obs_id.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_timeout got=%0d responses exp=%0d", obs_id.size(), n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 8;
        if (bus.req_ready !== '0)    begin n_err++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0)  begin n_err++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0)     begin n_err++; $display("FAIL rst_rsp_id got=%0d exp=0", bus.rsp_id); end
        if (bus.rsp_text !== '0)     begin n_err++; $display("FAIL rst_rsp_text got=%h exp=0", bus.rsp_text); end
        if (bus.core_kld !== 1'b0)   begin n_err++; $display("FAIL rst_core_kld got=%b exp=0", bus.core_kld); end
        if (bus.core_ld !== 1'b0)    begin n_err++; $display("FAIL rst_core_ld got=%b exp=0", bus.core_ld); end
        if (bus.core_key !== '0)     begin n_err++; $display("FAIL rst_core_key got=%h exp=0", bus.core_key); end
        if (bus.core_text_in !== '0) begin n_err++; $display("FAIL rst_core_text got=%h exp=0", bus.core_text_in); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_contention;
        int   g0, k0;
        int   order[5] = '{0, 1, 2, 3, 0};
        exp_t e;
        obs_id.delete(); obs_txt.delete(); exp_q.delete();
        g0 = gnt_q.size(); k0 = kld_n;
        fork
            begin
                req_job(0, {4{32'h1111_0000}}, {4{32'hc000_0000}});
                req_job(0, {4{32'h1111_0004}}, {4{32'hc000_0004}});
            end
            req_job(1, {4{32'h1111_0001}}, {4{32'hc000_0001}});
            req_job(2, {4{32'h1111_0002}}, {4{32'hc000_0002}});
            req_job(3, {4{32'h1111_0003}}, {4{32'hc000_0003}});
        join
        wait_obs(5);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (gnt_q.size() <= g0 + i) begin n_err++; $display("FAIL cont_order[%0d] got=none exp=%0d", i, order[i]); end
            else if (gnt_q[g0 + i] != order[i]) begin
                n_err++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, gnt_q[g0 + i], order[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (obs_id.size() > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp += 2;
                if (obs_id[0] != e.id)     begin n_err++; $display("FAIL cont_id[%0d] got=%0d exp=%0d", i, obs_id[0], e.id); end
                if (obs_txt[0] !== e.txt)  begin n_err++; $display("FAIL cont_text[%0d] got=%h exp=%h", i, obs_txt[0], e.txt); end
                void'(obs_id.pop_front()); void'(obs_txt.pop_front());
            end
        end
        n_cmp++;
        if (kld_n - k0 != 5) begin n_err++; $display("FAIL cont_kld_count got=%0d exp=5", kld_n - k0); end
    endtask

    task automatic test_single_job;
        int   k0, l0;
        exp_t e;
        obs_id.delete(); obs_txt.delete(); exp_q.delete();
        k0 = kld_n; l0 = ld_n;
        req_job(0, K0, C0);
        wait_obs(1);
        n_cmp += 5;
        if (kld_n - k0 != 1)       begin n_err++; $display("FAIL single_kld_count got=%0d exp=1", kld_n - k0); end
        if (ld_n - l0 != 1)        begin n_err++; $display("FAIL single_ld_count got=%0d exp=1", ld_n - l0); end
        if (kld_cyc != gnt_cyc + 1) begin n_err++; $display("FAIL single_kld_cyc got=%0d exp=%0d", kld_cyc, gnt_cyc + 1); end
        if (ld_cyc != gnt_cyc + 1 + KW) begin n_err++; $display("FAIL single_ld_cyc got=%0d exp=%0d", ld_cyc, gnt_cyc + 1 + KW); end
        if (rise_cyc != done_cyc + 1) begin n_err++; $display("FAIL single_rsp_lat got=%0d exp=%0d", rise_cyc, done_cyc + 1); end
        if (obs_id.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp += 2;
            if (obs_id[0] != 0)       begin n_err++; $display("FAIL single_id got=%0d exp=0", obs_id[0]); end
            if (obs_txt[0] !== P0)    begin n_err++; $display("FAIL single_text got=%h exp=%h", obs_txt[0], P0); end
            void'(obs_id.pop_front()); void'(obs_txt.pop_front());
        end
    endtask

    task automatic test_key_cache;
        int k0;
        obs_id.delete(); obs_txt.delete(); exp_q.delete();
        k0 = kld_n;
        req_job(1, K0, C0);
        wait_obs(1);
        n_cmp += 2;
`ifdef AES_INV_SCHED_KEYCACHE_EN
        if (kld_n - k0 != 0)        begin n_err++; $display("FAIL hit_kld_count got=%0d exp=0", kld_n - k0); end
        if (ld_cyc != gnt_cyc + 1)  begin n_err++; $display("FAIL hit_ld_cyc got=%0d exp=%0d", ld_cyc, gnt_cyc + 1); end
`else
        if (kld_n - k0 != 1)        begin n_err++; $display("FAIL hit_kld_count got=%0d exp=1", kld_n - k0); end
        if (ld_cyc != gnt_cyc + 1 + KW) begin n_err++; $display("FAIL hit_ld_cyc got=%0d exp=%0d", ld_cyc, gnt_cyc + 1 + KW); end
`endif
        if (obs_id.size() > 0) begin
            n_cmp += 2;
            if (obs_id[0] != 1)    begin n_err++; $display("FAIL hit_id got=%0d exp=1", obs_id[0]); end
            if (obs_txt[0] !== P0) begin n_err++; $display("FAIL hit_text got=%h exp=%h", obs_txt[0], P0); end
        end
    endtask

    task automatic test_backpressure;
        int           k0, l0, g0, bad, n;
        logic [1:0]   sv_id;
        logic [127:0] sv_txt;
        exp_t         e;
        obs_id.delete(); obs_txt.delete(); exp_q.delete();
        bus.rsp_ready = 1'b0;
        req_job(2, K0, {4{32'hbeef_0002}});
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        sv_id = bus.rsp_id; sv_txt = bus.rsp_text;
        k0 = kld_n; l0 = ld_n; g0 = gnt_q.size();
        bus.req_key[3] = {4{32'h3333_3333}}; bus.req_text[3] = '0; bus.req_valid[3] = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== sv_id || bus.rsp_text !== sv_txt || bus.req_ready !== '0) bad++;
        end
        n_cmp += 3;
        if (bad != 0)      begin n_err++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
        if (kld_n != k0)   begin n_err++; $display("FAIL bp_kld got=%0d exp=%0d", kld_n, k0); end
        if (ld_n != l0)    begin n_err++; $display("FAIL bp_ld got=%0d exp=%0d", ld_n, l0); end
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        bus.rsp_ready    = 1'b1;
        wait_obs(1);
        if (obs_id.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp += 2;
            if (obs_id[0] != e.id)    begin n_err++; $display("FAIL bp_id got=%0d exp=%0d", obs_id[0], e.id); end
            if (obs_txt[0] !== e.txt) begin n_err++; $display("FAIL bp_text got=%h exp=%h", obs_txt[0], e.txt); end
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (gnt_q.size() != g0) begin n_err++; $display("FAIL bp_withdrawn got=%0d grants exp=%0d", gnt_q.size(), g0); end
    endtask

    task automatic test_reset_mid;
        int k0;
        obs_id.delete(); obs_txt.delete(); exp_q.delete();
        req_job(0, {4{32'h5555_aaaa}}, {4{32'h0bad_f00d}});
        n_cmp++;
        if (bus.core_kld !== 1'b1) begin n_err++; $display("FAIL mid_kld got=%b exp=1", bus.core_kld); end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp += 8;
        if (bus.req_ready !== '0)    begin n_err++; $display("FAIL mid_req_ready got=%b exp=0", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0)  begin n_err++; $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0)     begin n_err++; $display("FAIL mid_rsp_id got=%0d exp=0", bus.rsp_id); end
        if (bus.rsp_text !== '0)     begin n_err++; $display("FAIL mid_rsp_text got=%h exp=0", bus.rsp_text); end
        if (bus.core_kld !== 1'b0)   begin n_err++; $display("FAIL mid_core_kld got=%b exp=0", bus.core_kld); end
        if (bus.core_ld !== 1'b0)    begin n_err++; $display("FAIL mid_core_ld got=%b exp=0", bus.core_ld); end
        if (bus.core_key !== '0)     begin n_err++; $display("FAIL mid_core_key got=%h exp=0", bus.core_key); end
        if (bus.core_text_in !== '0) begin n_err++; $display("FAIL mid_core_text got=%h exp=0", bus.core_text_in); end
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        obs_id.delete(); obs_txt.delete();
        k0 = kld_n;
        req_job(0, K0, C0);
        wait_obs(1);
        n_cmp++;
        if (kld_n - k0 != 1) begin n_err++; $display("FAIL mid_rekld got=%0d exp=1", kld_n - k0); end
        if (obs_id.size() > 0) begin
            n_cmp += 2;
            if (obs_id[0] != 0)    begin n_err++; $display("FAIL mid_id got=%0d exp=0", obs_id[0]); end
            if (obs_txt[0] !== P0) begin n_err++; $display("FAIL mid_text got=%h exp=%h", obs_txt[0], P0); end
        end
    endtask

    task automatic test_spurious_done;
        int bad = 0;
        obs_id.delete(); obs_txt.delete();
        repeat (2) @(posedge clk);
        #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        n_cmp += 3;
        if (bad != 0)          begin n_err++; $display("FAIL spur_rsp_valid got=%0d cycles exp=0", bad); end
        if (obs_id.size() != 0) begin n_err++; $display("FAIL spur_rsp_count got=%0d exp=0", obs_id.size()); end
        if (both_n != 0)       begin n_err++; $display("FAIL kld_ld_overlap got=%0d exp=0", both_n); end
    endtask

    initial begin
        spur = 1'b0;
        bus.req_valid = '0;
        bus.req_key   = '0;
        bus.req_text  = '0;
        bus.rsp_ready = 1'b1;
        test_reset;
        test_contention;
        test_single_job;
        test_key_cache;
        test_backpressure;
        test_reset_mid;
        test_spurious_done;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
